ex_div_ctrl: RTL and testbench
==============================

# ex_div_ctrl

Execute-stage controller for the multi-cycle integer divider. It decodes `div.w`, `mod.w`, `div.wu` and `mod.wu` in EX and drives the divider's start/signed/operand/annul inputs. It stalls EX while the divide runs, then selects the quotient or remainder and holds it until the MEM stage accepts it. Its downstream neighbour is the divider: the controller owns the divider's whole handshake, including cancellation on pipeline flush.

## Interface
Parameters:
- `CANCEL_CYC`, default 3: cycles spent in CANCEL with start low and annul high; must be ≥3.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  synchronous, active-low reset
- `ex_valid_i`  in  1  EX holds a valid instruction
- `ex_is_div_i`  in  1  EX instruction is one of the four divide ops
- `ex_op_i`  in  2  00 `div.w`, 01 `mod.w`, 10 `div.wu`, 11 `mod.wu`
- `src1_i`, `src2_i`  in  32  dividend, divisor
- `ex_flush_i`  in  1  exception/ertn flush of EX
- `ms_allowin_i`  in  1  MEM accepts the EX result this cycle
- `div_start_o`  out  1  divider start; held high for the whole request
- `div_signed_o`  out  1  signed operation (`ex_op_i[1]==0`)
- `div_op1_o`, `div_op2_o`  out  32  divider operands
- `div_annul_o`  out  1  abort the in-flight divide
- `div_result_i`  in  64  {remainder, quotient} from the divider
- `div_ready_i`  in  1  divider result valid
- `ex_div_stall_o`  out  1  EX may not advance
- `div_done_o`  out  1  `div_wdata_o` is valid
- `div_wdata_o`  out  32  selected result

## Operation
Divider contract:
- Start is sampled only when the divider is free.
- Ready stays high until start is seen low.
- A divide by zero returns 0/0.
- Operands and signed flag must stay constant from start until ready, because sign fix-up reads them live.

States:
- IDLE
  - Issue condition: `ex_valid_i & ex_is_div_i & ~ex_flush_i`.
  - On issue: `div_start_o`=1 combinationally, operands and signed flag passed straight from the inputs.
  - At the same edge, latch `src1`, `src2`, `op` into `op1_q`, `op2_q`, `op_q` and go to BUSY.
- BUSY
  - `div_start_o`=1; operands come from the latched registers.
  - `div_ready_i`=1: capture `wdata_q` = `op_q[0]` ? `div_result_i[63:32]` : `div_result_i[31:0]`, then go to DONE.
- DONE
  - `div_start_o`=0, which releases the divider; `div_done_o`=1.
  - `ms_allowin_i`=1: go to IDLE.
- CANCEL
  - `div_start_o`=0, `div_annul_o`=1.
  - Counts `CANCEL_CYC` cycles, then goes to IDLE.
  - The divider is guaranteed free on exit from every internal state, including its divide-by-zero path.

Flush handling:
- `ex_flush_i` in BUSY → CANCEL.
- `ex_flush_i` in DONE → IDLE; the result is discarded.
- `ex_flush_i` in IDLE suppresses issue.
- Flush has priority over a same-cycle `div_ready_i`.

Other output rules:
- `ex_div_stall_o` = `ex_valid_i & ex_is_div_i & ~ex_flush_i & ~(state==DONE)`. It is also high in CANCEL when EX holds a new divide.
- `div_annul_o`=1 only in CANCEL.
- `div_wdata_o` = `wdata_q`.

## Timing
Reset values: state IDLE; counter 0; `op1_q`, `op2_q`, `wdata_q` = 0; all outputs 0.

Latency:
- Issue cycle T, nonzero divisor: `div_ready_i` is seen at T+35, `div_done_o` at T+36.
- Zero divisor: ready at T+3, done at T+4.
- The controller waits on ready and never counts cycles.

Back-to-back:
- DONE lasts at least 1 cycle, so the divider samples start low and frees itself.
- The next divide may therefore issue in the cycle after DONE exits.
- `div_ready_i` is already 0 by that issue cycle.

Inputs held by stall: `src*` and `ex_op_i` are held by the EX stall, but only the latched copies are used after issue.

Reset mid-divide: returns to IDLE next edge. The divider shares the same reset.

## Test plan
- `div.w` 7 / 0xFFFFFFFE:
  - done after 36 cycles, `div_wdata_o`=0xFFFFFFFD.
  - `mod.w` on the same operands → 0x00000001.
- `div.wu` 0x80000000 / 3 → 0x2AAAAAAA; `mod.wu` → 0x00000002.
- `div.w` 5 / 0:
  - done at T+4, wdata=0.
  - Stall high T..T+3, low at T+4.
- `ex_flush_i` at T+10 of a `div.w`:
  - `div_annul_o` high for 3 cycles, no `div_done_o`.
  - A following `mod.w` -7/2 returns 0xFFFFFFFF.
- `ms_allowin_i`=0 for 5 cycles after done: `div_wdata_o` is held, `div_start_o` stays 0, and no new issue occurs until acceptance.
- Two back-to-back divides with `ms_allowin_i`=1: the second start asserts the cycle after DONE, and both results are correct.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: EX-stage controller for the multi-cycle divider.
// Issues div/mod ops, stalls EX, holds the result for MEM.
module ex_div_ctrl #(
   parameter int CANCEL_CYC = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid_i,
   input  logic        ex_is_div_i,
   input  logic [1:0]  ex_op_i,
   input  logic [31:0] src1_i,
   input  logic [31:0] src2_i,
   input  logic        ex_flush_i,
   input  logic        ms_allowin_i,
   output logic        div_start_o,
   output logic        div_signed_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   output logic        div_annul_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic        ex_div_stall_o,
   output logic        div_done_o,
   output logic [31:0] div_wdata_o
);

   localparam int CW = $clog2(CANCEL_CYC + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE,
      CANCEL
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   op1_q;
   logic [31:0]   op2_q;
   logic [31:0]   wdata_q;
   logic          rem_q;
   logic          signed_q;
   logic          done_q;
   logic          annul_q;
   logic          req;
   logic          issue;

   // EX holds a live divide request; issue only while idle
   assign req   = ex_valid_i & ex_is_div_i & ~ex_flush_i;
   assign issue = resetn & req & (state_q == IDLE);

   // operands pass straight through on issue, then come from latches
   assign div_start_o    = issue | (state_q == BUSY);
   assign div_op1_o      = issue ? src1_i : op1_q;
   assign div_op2_o      = issue ? src2_i : op2_q;
   assign div_signed_o   = issue ? ~ex_op_i[1] : signed_q;
   assign ex_div_stall_o = req & (state_q != DONE);
   assign div_done_o     = done_q;
   assign div_annul_o    = annul_q;
   assign div_wdata_o    = wdata_q;

   // control FSM with registered done/annul flags
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         wdata_q  <= '0;
         rem_q    <= 1'b0;
         signed_q <= 1'b0;
         done_q   <= 1'b0;
         annul_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (issue) begin
                  op1_q    <= src1_i;
                  op2_q    <= src2_i;
                  rem_q    <= ex_op_i[0];
                  signed_q <= ~ex_op_i[1];
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               if (ex_flush_i) begin
                  cnt_q   <= '0;
                  annul_q <= 1'b1;
                  state_q <= CANCEL;
               end else if (div_ready_i) begin
                  wdata_q <= rem_q ? div_result_i[63:32]
                                   : div_result_i[31:0];
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (ex_flush_i | ms_allowin_i) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            CANCEL: begin
               if (cnt_q == CW'(CANCEL_CYC - 1)) begin
                  cnt_q   <= '0;
                  annul_q <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed bench with a behavioural divider
// and a result scoreboard for ex_div_ctrl.
module tb_ex_div_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_is_div = 1'b0;
   logic [1:0]  ex_op = 2'b00;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        ex_flush = 1'b0;
   logic        ms_allowin = 1'b1;
   logic        div_start_o;
   logic        div_signed_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic        div_annul_o;
   logic [63:0] div_result;
   logic        div_ready;
   logic        ex_div_stall_o;
   logic        div_done_o;
   logic [31:0] div_wdata_o;

   int          npass = 0;
   int          ntot = 0;
   int          cyc = 0;
   int          last_issue = 0;
   int          last_done = 0;
   logic [31:0] expq[$];
   logic        done_prev = 1'b0;

   ex_div_ctrl #(.CANCEL_CYC(3)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .ex_valid_i    (ex_valid),
      .ex_is_div_i   (ex_is_div),
      .ex_op_i       (ex_op),
      .src1_i        (src1),
      .src2_i        (src2),
      .ex_flush_i    (ex_flush),
      .ms_allowin_i  (ms_allowin),
      .div_start_o   (div_start_o),
      .div_signed_o  (div_signed_o),
      .div_op1_o     (div_op1_o),
      .div_op2_o     (div_op2_o),
      .div_annul_o   (div_annul_o),
      .div_result_i  (div_result),
      .div_ready_i   (div_ready),
      .ex_div_stall_o(ex_div_stall_o),
      .div_done_o    (div_done_o),
      .div_wdata_o   (div_wdata_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural divider: ready after 35 cycles (3 on zero divisor),
   // held until start is seen low; annul frees it
   logic        dbusy = 1'b0;
   logic        dzero = 1'b0;
   int          dcnt = 0;
   logic        dready;
   logic [31:0] rq, rr;

   assign dready = dbusy && (dcnt >= (dzero ? 3 : 35));
   assign div_ready = dready;
   assign div_result = {rr, rq};

   always @(posedge clk) begin
      if (!resetn || div_annul_o) begin
         dbusy <= 1'b0;
         dcnt  <= 0;
      end else if (!dbusy) begin
         if (div_start_o) begin
            dbusy <= 1'b1;
            dcnt  <= 1;
            dzero <= (div_op2_o == 32'd0);
         end
      end else if (dready) begin
         if (!div_start_o) dbusy <= 1'b0;
      end else begin
         dcnt <= dcnt + 1;
      end
   end

   always_comb begin
      rq = '0;
      rr = '0;
      if (dready && !dzero && div_op2_o != 32'd0) begin
         if (div_signed_o) begin
            rq = $signed(div_op1_o) / $signed(div_op2_o);
            rr = $signed(div_op1_o) % $signed(div_op2_o);
         end else begin
            rq = div_op1_o / div_op2_o;
            rr = div_op1_o % div_op2_o;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   // scoreboard monitor: one pop per done assertion
   always @(negedge clk) begin
      if (resetn && div_done_o && !done_prev) begin
         if (expq.size() == 0) begin
            ntot++;
            $display("FAIL unexpected_done: got %h required none",
                     div_wdata_o);
         end else begin
            chk("result", div_wdata_o, expq.pop_front());
         end
      end
      done_prev <= div_done_o;
   end

   // called at drive time (#1 after posedge); returns at drive time
   task automatic run_div(input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat,
                          input int hold, input string nm);
      int   t0;
      logic stall_ok;
      logic seen;
      ex_valid   = 1'b1;
      ex_is_div  = 1'b1;
      ex_op      = op;
      src1       = a;
      src2       = b;
      ms_allowin = (hold == 0);
      expq.push_back(exp);
      t0 = cyc;
      last_issue = t0;
      @(negedge clk);
      chk({nm, "_start"}, {31'd0, div_start_o}, 32'd1);
      stall_ok = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (div_done_o) begin
            seen = 1'b1;
            break;
         end
         if (!ex_div_stall_o) stall_ok = 1'b0;
         @(negedge clk);
      end
      chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (!seen) begin
         void'(expq.pop_back());
         ms_allowin = 1'b1;
         ex_valid = 1'b0;
         ex_is_div = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      last_done = cyc;
      chk({nm, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
      chk({nm, "_latency"}, cyc - t0, lat);
      chk({nm, "_stall_done"}, {31'd0, ex_div_stall_o}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({nm, "_hold_done"}, {31'd0, div_done_o}, 32'd1);
         chk({nm, "_hold_wdata"}, div_wdata_o, exp);
         chk({nm, "_hold_start"}, {31'd0, div_start_o}, 32'd0);
      end
      ms_allowin = 1'b1;
      @(posedge clk);
      #1;
      ex_valid  = 1'b0;
      ex_is_div = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int acnt;
      int d1;
      logic dseen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_start", {31'd0, div_start_o}, 32'd0);
      chk("rst_done", {31'd0, div_done_o}, 32'd0);
      chk("rst_annul", {31'd0, div_annul_o}, 32'd0);
      chk("rst_signed", {31'd0, div_signed_o}, 32'd0);
      chk("rst_wdata", div_wdata_o, 32'd0);
      chk("rst_op1", div_op1_o, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(1);

      // signed quotient then remainder, back-to-back
      run_div(2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 36, 0, "divw");
      d1 = last_done;
      run_div(2'b01, 32'd7, 32'hFFFFFFFE, 32'h00000001, 36, 0, "modw");
      chk("b2b_gap", last_issue - d1, 32'd1);
      run_div(2'b10, 32'h80000000, 32'd3, 32'h2AAAAAAA, 36, 0, "divwu");
      run_div(2'b11, 32'h80000000, 32'd3, 32'h00000002, 36, 0, "modwu");

      // divide by zero: fast path
      idle(2);
      run_div(2'b00, 32'd5, 32'd0, 32'd0, 4, 0, "div0");

      // flush mid-divide
      idle(2);
      ex_valid  = 1'b1;
      ex_is_div = 1'b1;
      ex_op     = 2'b00;
      src1      = 32'd100;
      src2      = 32'd7;
      idle(10);
      ex_flush = 1'b1;
      @(negedge clk);
      chk("flush_pre_annul", {31'd0, div_annul_o}, 32'd0);
      @(posedge clk);
      #1;
      ex_flush  = 1'b0;
      ex_valid  = 1'b0;
      ex_is_div = 1'b0;
      acnt  = 0;
      dseen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (div_annul_o) begin
            acnt++;
            if (div_start_o) dseen = 1'b1;
         end
         if (div_done_o) dseen = 1'b1;
      end
      chk("flush_annul_cycles", acnt, 32'd3);
      chk("flush_no_done_start", {31'd0, dseen}, 32'd0);
      @(posedge clk);
      #1;
      run_div(2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 36, 0, "modw_neg");

      // MEM back-pressure holds the result
      idle(1);
      run_div(2'b10, 32'd100, 32'd7, 32'd14, 36, 4, "hold");

      // reset mid-divide
      ex_valid  = 1'b1;
      ex_is_div = 1'b1;
      ex_op     = 2'b00;
      src1      = 32'd9;
      src2      = 32'd2;
      idle(5);
      resetn    = 1'b0;
      ex_valid  = 1'b0;
      ex_is_div = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("midrst_start", {31'd0, div_start_o}, 32'd0);
      chk("midrst_done", {31'd0, div_done_o}, 32'd0);
      @(posedge clk);
      #1;
      run_div(2'b11, 32'd100, 32'd7, 32'd2, 36, 0, "post_rst");

      idle(3);
      chk("sb_empty", expq.size(), 32'd0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
